clock_bcd_sequencer: RTL and testbench

//  - Time-multiplexes one serial double-dabble (shift-add-3) BCD engine across hours, minutes, seconds.
//  - Replaces three parallel converters feeding the 7-seg decoders.
//  - On a time-update tick: snapshots the counters, converts hours -> minutes -> seconds, then publishes all six digits atomically.

---
 rtl/clock_bcd_sequencer.sv | 176 +++++++++++++++++
 tb/tb_clock_bcd_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_bcd_sequencer.sv
// rtl/clock_bcd_sequencer.sv - shared serial double-dabble BCD converter for hours/minutes/seconds
//
// One shift-add-3 engine is time-multiplexed over the three time fields.
// A tick snapshots the counters. The engine then converts hours, minutes and
// seconds in that order, and all six digits are published on a single edge.
//
// Optional feature macro: CLOCK_BCD_SEQUENCER_PENDING_EN
//   defined   - a tick accepted while busy is remembered and restarts the sequence
//   undefined - ticks while busy are dropped
//
// Parameters:
//   BIN_W        width of minutes/seconds inputs and iterations per field (6..7)
// Ports:
//   i_clk, i_reset_n         clock, synchronous active-low reset
//   i_en                     accept ticks when high
//   i_tick                   one-cycle strobe, time counters changed
//   i_seconds/i_minutes      binary seconds/minutes (BIN_W bits)
//   i_hours                  binary hours (5 bits)
//   o_*_msb / o_*_lsb        BCD tens / ones digits per field
//   o_busy                   sequence in progress
//   o_valid                  one-cycle pulse, new digits published
module clock_bcd_sequencer #(
    parameter int BIN_W = 6
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    input  logic             i_tick,
    input  logic [BIN_W-1:0] i_seconds,
    input  logic [BIN_W-1:0] i_minutes,
    input  logic [4:0]       i_hours,
    output logic [3:0]       o_hours_msb,
    output logic [3:0]       o_hours_lsb,
    output logic [3:0]       o_minutes_msb,
    output logic [3:0]       o_minutes_lsb,
    output logic [3:0]       o_seconds_msb,
    output logic [3:0]       o_seconds_lsb,
    output logic             o_busy,
    output logic             o_valid
);

    typedef enum logic [1:0] {IDLE, CONV, STORE} state_t;
    typedef enum logic [1:0] {F_HOURS, F_MINUTES, F_SECONDS} field_t;

    localparam int SR_W = BIN_W + 8;

    state_t            state, next_state;
    field_t            field;
    logic [2:0]        iter;
    // {tens, ones, bin}; the bin part doubles as the hours snapshot, since
    // hours are loaded straight into the engine on the capture edge.
    logic [SR_W-1:0]   sr;
    logic [BIN_W-1:0]  snap_m, snap_s;
    logic [3:0]        sh_hm, sh_hl, sh_mm, sh_ml;
    logic [3:0]        tens_adj, ones_adj;
    logic              accept;
    logic              start;

    assign accept = i_tick & i_en;

`ifdef CLOCK_BCD_SEQUENCER_PENDING_EN
    logic pending;
    assign start = pending | accept;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            pending <= 1'b0;
        end else if (state == IDLE) begin
            pending <= 1'b0;
        end else if (accept) begin
            // The publish edge (STORE/SECONDS) is still busy, so it lands here too.
            pending <= 1'b1;
        end
    end
`else
    assign start = accept;
`endif

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CONV;
            CONV:    if (iter == 3'(BIN_W - 1)) next_state = STORE;
            STORE:   next_state = (field == F_SECONDS) ? IDLE : CONV;
            default: next_state = IDLE;
        endcase
    end

    // Add-3 correction applied before each shift.
    always_comb begin
        ones_adj = sr[BIN_W+3:BIN_W];
        tens_adj = sr[BIN_W+7:BIN_W+4];
        if (ones_adj >= 4'd5) ones_adj = ones_adj + 4'd3;
        if (tens_adj >= 4'd5) tens_adj = tens_adj + 4'd3;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            field         <= F_HOURS;
            iter          <= '0;
            sr            <= '0;
            snap_m        <= '0;
            snap_s        <= '0;
            sh_hm         <= '0;
            sh_hl         <= '0;
            sh_mm         <= '0;
            sh_ml         <= '0;
            o_hours_msb   <= '0;
            o_hours_lsb   <= '0;
            o_minutes_msb <= '0;
            o_minutes_lsb <= '0;
            o_seconds_msb <= '0;
            o_seconds_lsb <= '0;
            o_valid       <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap_m <= i_minutes;
                        snap_s <= i_seconds;
                        sr     <= {8'd0, {(BIN_W-5){1'b0}}, i_hours};
                        field  <= F_HOURS;
                        iter   <= '0;
                    end
                end
                CONV: begin
                    // Tens MSB falls off the top: hundreds are discarded (mod 100).
                    sr   <= {tens_adj, ones_adj, sr[BIN_W-1:0]} << 1;
                    iter <= iter + 3'd1;
                end
                STORE: begin
                    iter <= '0;
                    case (field)
                        F_HOURS: begin
                            sh_hm <= sr[BIN_W+7:BIN_W+4];
                            sh_hl <= sr[BIN_W+3:BIN_W];
                            sr    <= {8'd0, snap_m};
                            field <= F_MINUTES;
                        end
                        F_MINUTES: begin
                            sh_mm <= sr[BIN_W+7:BIN_W+4];
                            sh_ml <= sr[BIN_W+3:BIN_W];
                            sr    <= {8'd0, snap_s};
                            field <= F_SECONDS;
                        end
                        default: begin
                            // Seconds go straight from the engine to the outputs
                            // so all six digits change on this one edge.
                            o_hours_msb   <= sh_hm;
                            o_hours_lsb   <= sh_hl;
                            o_minutes_msb <= sh_mm;
                            o_minutes_lsb <= sh_ml;
                            o_seconds_msb <= sr[BIN_W+7:BIN_W+4];
                            o_seconds_lsb <= sr[BIN_W+3:BIN_W];
                            o_valid       <= 1'b1;
                            field         <= F_HOURS;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_bcd_sequencer.sv
// tb/tb_clock_bcd_sequencer.sv - directed self-checking bench for clock_bcd_sequencer
`timescale 1ns/1ps
module tb_clock_bcd_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b1;
    logic       tick = 1'b0;
    logic [5:0] seconds = '0, minutes = '0;
    logic [4:0] hours = '0;
    logic [3:0] hm, hl, mm, ml, sm, sl;
    logic       busy, valid;

    logic       tick7 = 1'b0;
    logic [6:0] seconds7 = '0, minutes7 = '0;
    logic [4:0] hours7 = '0;
    logic [3:0] hm7, hl7, mm7, ml7, sm7, sl7;
    logic       busy7, valid7;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clock_bcd_sequencer #(.BIN_W(6)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_en(en), .i_tick(tick),
        .i_seconds(seconds), .i_minutes(minutes), .i_hours(hours),
        .o_hours_msb(hm), .o_hours_lsb(hl),
        .o_minutes_msb(mm), .o_minutes_lsb(ml),
        .o_seconds_msb(sm), .o_seconds_lsb(sl),
        .o_busy(busy), .o_valid(valid)
    );

    clock_bcd_sequencer #(.BIN_W(7)) dut7 (
        .i_clk(clk), .i_reset_n(reset_n), .i_en(en), .i_tick(tick7),
        .i_seconds(seconds7), .i_minutes(minutes7), .i_hours(hours7),
        .o_hours_msb(hm7), .o_hours_lsb(hl7),
        .o_minutes_msb(mm7), .o_minutes_lsb(ml7),
        .o_seconds_msb(sm7), .o_seconds_lsb(sl7),
        .o_busy(busy7), .o_valid(valid7)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] digits();
        return {8'h00, hm, hl, mm, ml, sm, sl};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Tick with the given time; returns edges from capture to o_valid and busy cycles.
    task automatic run_seq(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                           output int lat, output int bcnt);
        hours = h; minutes = m; seconds = s;
        tick = 1'b1;
        step();
        tick = 1'b0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!valid && lat < 60) begin
            step();
            lat++;
            if (busy) bcnt++;
        end
    endtask

    initial begin
        int lat, bcnt, vcnt, bsum, t1, t2;
        logic [31:0] d1, d2;

        // Reset state
        step(); step(); step();
        check("reset_digits", digits(), 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        reset_n = 1'b1;
        step();

        // 23:59:58
        run_seq(5'd23, 6'd59, 6'd58, lat, bcnt);
        check("t1_latency", lat, 21);
        check("t1_busy_cycles", bcnt, 21);
        check("t1_digits", digits(), 32'h235958);
        step();
        check("t1_valid_pulse", {31'd0, valid}, 32'd0);

        // Out-of-range inputs convert literally
        run_seq(5'd0, 6'd63, 6'd60, lat, bcnt);
        check("t2_latency", lat, 21);
        check("t2_digits", digits(), 32'h006360);

        // Inputs change during conversion; snapshot is what gets published
        hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step(); step(); step();
        hours = 5'd1; minutes = 6'd2; seconds = 6'd3;
        vcnt = 0;
        for (int k = 4; k <= 20; k++) begin
            step();
            if (valid) vcnt++;
        end
        check("t3_no_early_valid", vcnt, 0);
        check("t3_hold_digits", digits(), 32'h006360);
        step();
        check("t3_valid", {31'd0, valid}, 32'd1);
        check("t3_digits", digits(), 32'h123456);
        step();

        // Second tick while busy at capture+5
        hours = 5'd1; minutes = 6'd2; seconds = 6'd3;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step(); step(); step(); step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        hours = 5'd4; minutes = 6'd5; seconds = 6'd6;
        vcnt = 0; t1 = 0; t2 = 0; d1 = '0; d2 = '0;
        for (int k = 6; k <= 50; k++) begin
            step();
            if (valid) begin
                vcnt++;
                if (vcnt == 1) begin t1 = k; d1 = digits(); end
                else begin t2 = k; d2 = digits(); end
            end
        end
        check("t4_first_time", t1, 21);
        check("t4_first_digits", d1, 32'h010203);
`ifdef CLOCK_BCD_SEQUENCER_PENDING_EN
        check("t4_valid_count", vcnt, 2);
        check("t4_second_time", t2, 43);
        check("t4_second_digits", d2, 32'h040506);
`else
        check("t4_valid_count", vcnt, 1);
        check("t4_final_digits", digits(), 32'h010203);
`endif

        // Reset in the middle of a sequence
        hours = 5'd10; minutes = 6'd20; seconds = 6'd30;
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int k = 1; k <= 9; k++) step();
        reset_n = 1'b0;
        step();
        check("t5_reset_digits", digits(), 32'h0);
        check("t5_reset_busy", {31'd0, busy}, 32'd0);
        check("t5_reset_valid", {31'd0, valid}, 32'd0);
        reset_n = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (valid) vcnt++;
        end
        check("t5_no_valid_after_abort", vcnt, 0);
        run_seq(5'd7, 6'd8, 6'd9, lat, bcnt);
        check("t5_clean_latency", lat, 21);
        check("t5_clean_digits", digits(), 32'h070809);

        // Enable low: tick ignored
        en = 1'b0;
        hours = 5'd11; minutes = 6'd11; seconds = 6'd11;
        tick = 1'b1;
        step();
        tick = 1'b0;
        vcnt = 0; bsum = 0;
        for (int k = 0; k < 25; k++) begin
            if (busy) bsum++;
            if (valid) vcnt++;
            step();
        end
        check("t6_no_busy", bsum, 0);
        check("t6_no_valid", vcnt, 0);
        check("t6_hold_digits", digits(), 32'h070809);
        en = 1'b1;

        // Ticks every 22 cycles
        vcnt = 0;
        for (int c = 0; c <= 70; c++) begin
            if (c % 22 == 0 && c <= 44) begin
                hours = 5'(c / 22 + 1); minutes = 6'(c / 22 + 1); seconds = 6'(c / 22 + 1);
                tick = 1'b1;
            end else begin
                tick = 1'b0;
            end
            step();
            if (valid) vcnt++;
        end
        tick = 1'b0;
        check("t7_valid_count", vcnt, 3);
        check("t7_final_digits", digits(), 32'h030303);

        // BIN_W=7: values >= 100 wrap modulo 100
        hours7 = 5'd23; minutes7 = 7'd99; seconds7 = 7'd127;
        tick7 = 1'b1;
        step();
        tick7 = 1'b0;
        lat = 0;
        while (!valid7 && lat < 60) begin
            step();
            lat++;
        end
        check("t8_latency", lat, 24);
        check("t8_digits", {8'h00, hm7, hl7, mm7, ml7, sm7, sl7}, 32'h239927);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
